// File: rtl/matmul_dot_engine.sv
// Matrix-multiply core: walks C[r][c] in row-major order, fetches A row r and
// B column c from the loader, MACs LANES products per cycle and emits one byte per element.
module matmul_dot_engine #(
  parameter int unsigned N      = 32,
  parameter int unsigned ELEM_W = 8,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned LANES  = 4
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  complete,
  input  logic [N*ELEM_W-1:0]   matA_row,
  input  logic [N*ELEM_W-1:0]   matB_col,
  input  logic [ADDR_W-1:0]     row_in,
  input  logic [ADDR_W-1:0]     col_in,
  input  logic                  val_rows,
  output logic [ADDR_W-1:0]     row_req,
  output logic [ADDR_W-1:0]     col_req,
  output logic [ELEM_W-1:0]     matrix_val,
  output logic [ADDR_W-1:0]     row_out,
  output logic [ADDR_W-1:0]     col_out,
  output logic                  valid_out,
  output logic                  done,
  output logic                  busy
);

  localparam int unsigned ACC_W  = 2*ELEM_W + $clog2(N);
  localparam int unsigned SLICES = N / LANES;
  localparam int unsigned IDX_W  = (SLICES > 1) ? $clog2(SLICES) : 1;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_MAC, S_EMIT, S_DONE} state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   r, c, r_adv, c_adv;
  logic [IDX_W-1:0]    idx;
  logic [N*ELEM_W-1:0] a_vec, b_vec;
  logic [ACC_W-1:0]    acc, slice_sum, acc_sum;
  logic                hit, last_slice, last_elem;

  assign hit        = val_rows && (row_in == r) && (col_in == c);
  assign last_slice = (idx == IDX_W'(SLICES - 1));
  assign last_elem  = (r == ADDR_W'(N - 1)) && (c == ADDR_W'(N - 1));
  assign done       = (state == S_DONE);
  assign busy       = (state == S_WAIT) || (state == S_MAC) || (state == S_EMIT);

  always_comb begin
    c_adv = c + 1'b1;
    r_adv = r;
    if (c == ADDR_W'(N - 1)) begin
      c_adv = '0;
      r_adv = r + 1'b1;
    end
  end

  // Captured vectors shift down one slice per MAC cycle, so the lanes always read the low end.
  always_comb begin
    slice_sum = '0;
    for (int unsigned l = 0; l < LANES; l++)
      slice_sum = slice_sum + ACC_W'(a_vec[l*ELEM_W +: ELEM_W]) * ACC_W'(b_vec[l*ELEM_W +: ELEM_W]);
    acc_sum = acc + slice_sum;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (complete)   state_nxt = S_WAIT;
      S_WAIT:  if (hit)        state_nxt = S_MAC;
      S_MAC:   if (last_slice) state_nxt = S_EMIT;
      S_EMIT:  state_nxt = last_elem ? S_DONE : S_WAIT;
      S_DONE:  if (!complete)  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r          <= '0;
      c          <= '0;
      idx        <= '0;
      a_vec      <= '0;
      b_vec      <= '0;
      acc        <= '0;
      row_req    <= '0;
      col_req    <= '0;
      matrix_val <= '0;
      row_out    <= '0;
      col_out    <= '0;
      valid_out  <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      case (state)
        S_IDLE: if (complete) begin
          r       <= '0;
          c       <= '0;
          row_req <= '0;
          col_req <= '0;
        end
        S_WAIT: if (hit) begin
          a_vec <= matA_row;
          b_vec <= matB_col;
          acc   <= '0;
          idx   <= '0;
        end
        S_MAC: begin
          acc   <= acc_sum;
          idx   <= idx + 1'b1;
          a_vec <= a_vec >> (LANES*ELEM_W);
          b_vec <= b_vec >> (LANES*ELEM_W);
          // Result registers load on the edge into EMIT so they are valid during the strobe.
          if (last_slice) begin
            valid_out  <= 1'b1;
            matrix_val <= acc_sum[ELEM_W-1:0];
            row_out    <= r;
            col_out    <= c;
          end
        end
        S_EMIT: begin
          r       <= r_adv;
          c       <= c_adv;
          row_req <= r_adv;
          col_req <= c_adv;
        end
        default: ;
      endcase
    end
  end

endmodule
